// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and sizing for the dispatch throttle controller.
// Slot width N and branch-mask width follow the core configuration.
package dispatch_ctrl_pkg;

  localparam int unsigned N               = 3;
  localparam int unsigned B_MASK_WIDTH    = 4;
  localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int unsigned B_CNT_BITS      = $clog2(B_MASK_WIDTH + 1);
  localparam int unsigned RCNT_BITS       = 4;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SERIAL_WAIT = 2'd1,
    RECOVER     = 2'd2
  } dispatch_ctrl_state_e;

  typedef logic [NUM_SCALAR_BITS-1:0] slot_cnt_t;

  function automatic slot_cnt_t min_cnt(input slot_cnt_t a, input slot_cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dispatch_prefix_limit.sv
// Combinational prefix limits over the fetch packet: how many leading slots fit
// the free branch-stack entries, and where the first serializing slot sits.
module dispatch_prefix_limit
  import dispatch_ctrl_pkg::*;
(
  input  logic [NUM_SCALAR_BITS-1:0] instructions_valid,
  input  logic [N-1:0]               branch_slots,
  input  logic [N-1:0]               serial_slots,
  input  logic [B_CNT_BITS-1:0]      bs_free,
  output logic [NUM_SCALAR_BITS-1:0] lim_br,
  output logic [NUM_SCALAR_BITS-1:0] lim_ser
);

  logic [N-1:0] valid_mask;
  int unsigned  br_seen;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < N; i++) begin
      valid_mask[i] = (NUM_SCALAR_BITS'(i) < instructions_valid);
    end
  end

  // Branch demand only grows with k, so the last prefix that fits is the largest.
  always_comb begin
    br_seen = '0;
    lim_br  = '0;
    for (int k = 0; k < N; k++) begin
      br_seen = br_seen + 32'(branch_slots[k] & valid_mask[k]);
      if (br_seen <= 32'(bs_free)) begin
        lim_br = NUM_SCALAR_BITS'(k + 1);
      end
    end
  end

  always_comb begin
    lim_ser = NUM_SCALAR_BITS'(N);
    for (int k = N - 1; k >= 0; k--) begin
      if (serial_slots[k] && valid_mask[k]) begin
        lim_ser = NUM_SCALAR_BITS'(k);
      end
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch throttle: per-cycle slot count from resources, branch stack and
// serializers, with an FSM for mispredict recovery and serializer ROB drain.
// Optional performance counters are built when DISPATCH_CTRL_PERF_EN is defined.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SCALAR_BITS-1:0] instructions_valid,
  input  logic [N-1:0]               branch_slots,
  input  logic [N-1:0]               serial_slots,
  input  logic [NUM_SCALAR_BITS-1:0] rob_spots,
  input  logic                       rob_empty,
  input  logic [NUM_SCALAR_BITS-1:0] rs_spots,
  input  logic [NUM_SCALAR_BITS-1:0] num_regs_available,
  input  logic [B_CNT_BITS-1:0]      bs_free,
  input  logic                       restore_valid,
  output logic [NUM_SCALAR_BITS-1:0] num_dispatched,
  output logic                       dispatch_stall,
  output logic [1:0]                 ctrl_state
`ifdef DISPATCH_CTRL_PERF_EN
  ,
  output logic [31:0]                stall_count,
  output logic [31:0]                recover_count
`endif
);

  dispatch_ctrl_state_e state_q, state_d;
  logic [RCNT_BITS-1:0] rcnt_q, rcnt_d;
  slot_cnt_t            lim_res, lim_br, lim_ser, base, nd;

  dispatch_prefix_limit u_prefix (
    .instructions_valid (instructions_valid),
    .branch_slots       (branch_slots),
    .serial_slots       (serial_slots),
    .bs_free            (bs_free),
    .lim_br             (lim_br),
    .lim_ser            (lim_ser)
  );

  assign lim_res = min_cnt(min_cnt(instructions_valid, rob_spots),
                           min_cnt(rs_spots, num_regs_available));
  assign base    = min_cnt(lim_res, min_cnt(lim_br, lim_ser));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    nd      = '0;
    if (restore_valid) begin
      if (RECOVER_CYCLES == 0) begin
        state_d = RUN;
        rcnt_d  = '0;
      end else begin
        state_d = RECOVER;
        rcnt_d  = RCNT_BITS'(RECOVER_CYCLES);
      end
    end else begin
      unique case (state_q)
        RUN: begin
          nd = base;
          // A serializer at slot 0 goes alone, and only once older work has drained.
          if (base == '0 && instructions_valid != '0 && serial_slots[0]) begin
            if (rob_empty) begin
              if (lim_res != '0 && lim_br != '0) nd = slot_cnt_t'(1);
            end else begin
              state_d = SERIAL_WAIT;
            end
          end
        end
        SERIAL_WAIT: begin
          if (rob_empty && lim_res != '0) begin
            nd      = slot_cnt_t'(1);
            state_d = RUN;
          end
        end
        RECOVER: begin
          if (rcnt_q <= RCNT_BITS'(1)) begin
            rcnt_d  = '0;
            state_d = RUN;
          end else begin
            rcnt_d = rcnt_q - RCNT_BITS'(1);
          end
        end
        default: begin
          state_d = RUN;
          rcnt_d  = '0;
        end
      endcase
    end
    if (reset) nd = '0;
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign num_dispatched = nd;
  assign dispatch_stall = !reset && (instructions_valid != '0) && (nd == '0);
  assign ctrl_state     = state_q;

`ifdef DISPATCH_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, rec_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      rec_cnt_q   <= '0;
    end else begin
      if (dispatch_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == RECOVER || restore_valid) && rec_cnt_q != '1)
        rec_cnt_q <= rec_cnt_q + 32'd1;
    end
  end

  assign stall_count   = stall_cnt_q;
  assign recover_count = rec_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed literal cases plus random
// traffic compared every cycle against a slot-rule reference model.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int RC = 2;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [NUM_SCALAR_BITS-1:0] instructions_valid;
  logic [N-1:0]               branch_slots, serial_slots;
  logic [NUM_SCALAR_BITS-1:0] rob_spots, rs_spots, num_regs_available;
  logic                       rob_empty, restore_valid;
  logic [B_CNT_BITS-1:0]      bs_free;
  logic [NUM_SCALAR_BITS-1:0] num_dispatched;
  logic                       dispatch_stall;
  logic [1:0]                 ctrl_state;
`ifdef DISPATCH_CTRL_PERF_EN
  logic [31:0]                stall_count, recover_count;
`endif

  dispatch_ctrl #(.RECOVER_CYCLES(RC)) dut (
    .clock              (clock),
    .reset              (reset),
    .instructions_valid (instructions_valid),
    .branch_slots       (branch_slots),
    .serial_slots       (serial_slots),
    .rob_spots          (rob_spots),
    .rob_empty          (rob_empty),
    .rs_spots           (rs_spots),
    .num_regs_available (num_regs_available),
    .bs_free            (bs_free),
    .restore_valid      (restore_valid),
    .num_dispatched     (num_dispatched),
    .dispatch_stall     (dispatch_stall),
    .ctrl_state         (ctrl_state)
`ifdef DISPATCH_CTRL_PERF_EN
    ,
    .stall_count        (stall_count),
    .recover_count      (recover_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: hold cycles remaining after a mispredict, and a flag for
  // a serializer waiting on the ROB to drain.
  int hold = 0, hold_n = 0;
  bit waiting = 0, waiting_n = 0;
  int m_stall_cnt = 0, m_rec_cnt = 0, m_stall_n = 0, m_rec_n = 0;
  int exp_nd, exp_state;
  bit exp_stall;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int branch_limit(int iv, int br, int bsf);
    int best = 0;
    for (int k = 0; k <= N; k++) begin
      int pc = 0;
      for (int i = 0; i < k && i < iv; i++) pc += (br >> i) & 1;
      if (pc <= bsf) best = k;
    end
    return best;
  endfunction

  function automatic int serial_limit(int iv, int ser);
    for (int i = 0; i < iv; i++) if (((ser >> i) & 1) == 1) return i;
    return N;
  endfunction

  task automatic model_eval();
    int iv, lres, lbr, lser, b;
    iv   = int'(instructions_valid);
    lres = imin(imin(iv, int'(rob_spots)), imin(int'(rs_spots), int'(num_regs_available)));
    lbr  = branch_limit(iv, int'(branch_slots), int'(bs_free));
    lser = serial_limit(iv, int'(serial_slots));
    b    = imin(lres, imin(lbr, lser));
    exp_nd    = 0;
    exp_state = (hold > 0) ? 2 : (waiting ? 1 : 0);
    hold_n    = hold;
    waiting_n = waiting;
    if (reset) begin
      exp_state = 0;
      hold_n = 0;
      waiting_n = 0;
    end else if (restore_valid) begin
      hold_n = RC;
      waiting_n = 0;
    end else if (hold > 0) begin
      hold_n = hold - 1;
    end else if (waiting) begin
      if (rob_empty && lres >= 1) begin
        exp_nd = 1;
        waiting_n = 0;
      end
    end else begin
      exp_nd = b;
      if (b == 0 && iv > 0 && serial_slots[0]) begin
        if (rob_empty) exp_nd = (lres >= 1 && lbr >= 1) ? 1 : 0;
        else waiting_n = 1;
      end
    end
    exp_stall = !reset && iv != 0 && exp_nd == 0;
    if (reset) begin
      m_stall_n = 0;
      m_rec_n   = 0;
    end else begin
      m_stall_n = m_stall_cnt + (exp_stall ? 1 : 0);
      m_rec_n   = m_rec_cnt + ((hold > 0 || restore_valid) ? 1 : 0);
    end
  endtask

  // Single compare process: outputs checked against the model every cycle.
  always @(negedge clock) begin
    model_eval();
    check("num_dispatched", 32'(num_dispatched), exp_nd);
    check("dispatch_stall", 32'(dispatch_stall), 32'(exp_stall));
    check("ctrl_state", 32'(ctrl_state), exp_state);
`ifdef DISPATCH_CTRL_PERF_EN
    check("stall_count", stall_count, (reset ? 0 : m_stall_cnt));
    check("recover_count", recover_count, (reset ? 0 : m_rec_cnt));
`endif
  end

  always @(posedge clock) begin
    hold        = hold_n;
    waiting     = waiting_n;
    m_stall_cnt = m_stall_n;
    m_rec_cnt   = m_rec_n;
  end

  task automatic drive(input int iv, input int br, input int ser, input int rob, input int rs,
                       input int regs, input int bsf, input bit empty, input bit rv, input bit rst);
    @(posedge clock);
    #1;
    instructions_valid = slot_cnt_t'(iv);
    branch_slots       = N'(br);
    serial_slots       = N'(ser);
    rob_spots          = slot_cnt_t'(rob);
    rs_spots           = slot_cnt_t'(rs);
    num_regs_available = slot_cnt_t'(regs);
    bs_free            = B_CNT_BITS'(bsf);
    rob_empty          = empty;
    restore_valid      = rv;
    reset              = rst;
  endtask

  task automatic expect_lit(input string name, input int nd, input int st, input int stall);
    @(negedge clock);
    #1;
    check({name, ".nd"}, 32'(num_dispatched), nd);
    check({name, ".state"}, 32'(ctrl_state), st);
    check({name, ".stall"}, 32'(dispatch_stall), stall);
  endtask

  initial begin
    reset = 1'b1;
    instructions_valid = 2'd3; branch_slots = '0; serial_slots = '0;
    rob_spots = 2'd3; rs_spots = 2'd3; num_regs_available = 2'd3;
    bs_free = 3'd4; rob_empty = 1'b0; restore_valid = 1'b0;

    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 1); expect_lit("reset_hold", 0, 0, 0);
    drive(3, 0, 0, 3, 2, 3, 4, 0, 0, 0); expect_lit("res_limit", 2, 0, 0);
    drive(3, 3, 0, 3, 3, 3, 1, 0, 0, 0); expect_lit("br_limit", 1, 0, 0);
    drive(3, 3, 0, 3, 3, 3, 0, 0, 0, 0); expect_lit("br_full", 0, 0, 1);
    drive(0, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("iv_zero", 0, 0, 0);
    drive(3, 0, 0, 0, 3, 3, 4, 0, 0, 0); expect_lit("rob_full", 0, 0, 1);

    drive(3, 0, 0, 3, 3, 3, 4, 0, 1, 0); expect_lit("rec_pulse", 0, 0, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("rec_1", 0, 2, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("rec_2", 0, 2, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("rec_done", 3, 0, 0);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 1, 0); expect_lit("ext_pulse", 0, 0, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("ext_1", 0, 2, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 1, 0); expect_lit("ext_pulse2", 0, 2, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("ext_2", 0, 2, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("ext_3", 0, 2, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0); expect_lit("ext_done", 3, 0, 0);

    drive(3, 0, 4, 3, 3, 3, 4, 0, 0, 0); expect_lit("ser_slot2", 2, 0, 0);
    drive(3, 0, 1, 3, 3, 3, 4, 0, 0, 0); expect_lit("ser_busy", 0, 0, 1);
    drive(3, 0, 1, 3, 3, 3, 4, 1, 0, 0); expect_lit("ser_drain", 1, 1, 0);
    drive(3, 0, 0, 3, 3, 3, 4, 1, 0, 0); expect_lit("ser_back", 3, 0, 0);
    drive(3, 1, 1, 3, 3, 3, 4, 1, 0, 0); expect_lit("ser_empty", 1, 0, 0);

    drive(3, 0, 0, 3, 3, 3, 4, 0, 1, 0); expect_lit("rst_pulse", 0, 0, 1);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 1); expect_lit("rst_mid_rec", 0, 0, 0);
    drive(3, 0, 0, 3, 2, 3, 4, 0, 0, 0); expect_lit("rst_after", 2, 0, 0);

`ifdef DISPATCH_CTRL_PERF_EN
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(3, 0, 0, 0, 3, 3, 4, 0, 0, 0);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 1, 0);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0);
    drive(3, 0, 0, 3, 3, 3, 4, 0, 0, 0);
    @(negedge clock);
    #1;
    check("perf.stall_count", stall_count, 6);
    check("perf.recover_count", recover_count, 3);
`endif

    for (int c = 0; c < 3000; c++) begin
      int ser;
      ser = 0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) ser |= (1 << i);
      drive($urandom_range(0, 3), $urandom_range(0, 7), ser,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3,
            $urandom_range(0, 5), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    drive(0, 0, 0, 3, 3, 3, 4, 1, 0, 0);
    @(negedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
